fifo_stream_checker: RTL and testbench
======================================

// Module: fifo_stream_checker
// PURPOSE
//  Synthesizable read-side consumer and checker for a first-word-fall-through (FWFT) FIFO.
//  Drains a block of LENGTH words and compares each word against a locally regenerated LFSR stream.
//  Reports the error count, the first failing index and a done flag.
//  Sits on the FIFO dout/rd_en/empty port as the hardware counterpart of the block writer.
// PARAMETERS
//  DATA_WIDTH  16            FIFO word width; legal range 1..32
//  SEED        32'hACE1_0001 expected-stream LFSR seed, reloaded on every start; must be nonzero
//  POLY        32'h8020_0003 Galois LFSR feedback taps (32-bit, maximal length)
//  RATE        8'd192        throttle threshold: read allowed when tlfsr[7:0] < RATE
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, asynchronous, active-low
//  start          in   1   begin a block; sampled in IDLE/DONE, ignored in RUN
//  length         in   16  words to consume; latched on start
//  din            in   DW  FIFO dout; valid whenever empty=0 (FWFT)
//  empty          in   1   FIFO empty
//  rd_en          out  1   consume din this cycle
//  busy           out  1   state==RUN
//  done           out  1   level, high in DONE
//  words_read     out  16  words consumed in the current block
//  err_count      out  16  mismatches, saturates at 16'hFFFF
//  first_err_idx  out  16  index of the first mismatch; 16'hFFFF if none
// BEHAVIOUR
//  - Reset (async, rst=0): state=IDLE; rd_en=0 (combinational, so low immediately); busy=0; done=0;
//    words_read=0; err_count=0; first_err_idx=16'hFFFF; exp_lfsr=SEED; tlfsr=32'h1.
//  - FSM:
//    - IDLE --start--> RUN.
//    - RUN: when words_read==len, or on the consume cycle of the last word, go to DONE.
//    - DONE --start--> RUN. A start in DONE clears the counters exactly as a start in IDLE does.
//  - start action: latch len=length; clear words_read and err_count; first_err_idx=FFFF; exp_lfsr=SEED.
//  - length=0: RUN lasts exactly 1 cycle with rd_en=0, then DONE.
//  - rd_en = (state==RUN) & ~empty & allow & (words_read<len). Never high when empty=1.
//  - Consume cycle (rd_en=1):
//    - compare din against exp_lfsr[DW-1:0];
//    - on mismatch, err_count+1 (saturating); if first_err_idx==FFFF, first_err_idx=words_read;
//    - exp_lfsr advances one step; words_read+1.
//  - LFSR step: nxt = {1'b0,s[31:1]} ^ (s[0] ? POLY : 0). No advance on non-consume cycles.
//  - Latency: done rises on the cycle after the last consume. Zero-bubble back-to-back reads are possible.
//  - words_read counts only consumes; empty toggling and throttle stalls do not advance it.
// CONFIGURATION
//  FIFO_STREAM_CHECKER_THROTTLE_EN:
//  - defined: a second LFSR (tlfsr, same POLY) steps every cycle while in RUN;
//    allow = (tlfsr[7:0] < RATE), giving a pseudo-random read duty of ~RATE/256.
//  - undefined: allow=1 and tlfsr is not instantiated; RATE is ignored.
// STRUCTURE
//  - fifo_check_pkg: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), NO_ERR=16'hFFFF,
//    default POLY/SEED constants, and function lfsr32_next(s, poly).
//  - Sub-module lfsr32 (state reg + load/step enables). Instantiated once for the expected stream,
//    and once more for the throttle when enabled.
// TESTING
//  1. FIFO preloaded with the 4 correct SEED words, length=4, start, no throttle ->
//     rd_en high 4 consecutive cycles; done 1 cycle later; err_count=0; first_err_idx=FFFF.
//  2. Same as 1 but word 2 XOR 16'h0001 -> err_count=1, first_err_idx=2, words_read=4.
//  3. empty toggled 1/0 every cycle over 8 words -> rd_en only when empty=0;
//     words_read=8 after 16 cycles; err_count=0.
//  4. length=0, start -> done high 2 cycles after start; rd_en never asserted.
//  5. rst=0 after 3 consumes -> rd_en=0 same cycle; words_read=0; done=0; next start restarts from SEED.
//  6. THROTTLE_EN, RATE=128, 128 correct words -> rd_en duty 40..60%; err_count=0; done asserted.

Source files
------------

// File: rtl/fifo_check_pkg.sv
// fifo_check_pkg: shared state encoding, constants and LFSR step function
// for the FWFT FIFO stream checker.
//   state_t      : IDLE / RUN / DONE checker states
//   NO_ERR       : first-error index value meaning "no mismatch seen"
//   DEF_POLY     : default 32-bit maximal-length Galois feedback taps
//   DEF_SEED     : default expected-stream seed (nonzero)
//   lfsr32_next  : one Galois LFSR step
package fifo_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] NO_ERR   = 16'hFFFF;
    localparam logic [31:0] DEF_POLY = 32'h8020_0003;
    localparam logic [31:0] DEF_SEED = 32'hACE1_0001;

    function automatic logic [31:0] lfsr32_next(input logic [31:0] s, input logic [31:0] poly);
        return {1'b0, s[31:1]} ^ (s[0] ? poly : 32'h0);
    endfunction

endpackage

// File: rtl/fifo_stream_checker_lfsr32.sv
// lfsr32: 32-bit Galois LFSR register with synchronous load and step enables.
//   clk      in   clock
//   rst      in   asynchronous active-low reset, state returns to INIT
//   i_load   in   load i_seed (has priority over i_step)
//   i_seed   in   value loaded by i_load
//   i_step   in   advance one LFSR step
//   o_state  out  current LFSR state
module lfsr32
    import fifo_check_pkg::*;
#(
    parameter logic [31:0] POLY = DEF_POLY,
    parameter logic [31:0] INIT = 32'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_seed,
    input  logic        i_step,
    output logic [31:0] o_state
);

    logic [31:0] r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= INIT;
        else if (i_load)
            r_state <= i_seed;
        else if (i_step)
            r_state <= lfsr32_next(r_state, POLY);
    end

    assign o_state = r_state;

endmodule

// File: rtl/fifo_stream_checker.sv
// fifo_stream_checker: drains a block of words from an FWFT FIFO and checks
// them against a locally regenerated LFSR stream.
// Optional feature macro: FIFO_STREAM_CHECKER_THROTTLE_EN (pseudo-random read
// throttle driven by a second LFSR; read allowed when tlfsr[7:0] < RATE).
//   clk              in   clock
//   rst              in   asynchronous active-low reset
//   i_start          in   begin a block (honoured in IDLE/DONE only)
//   i_length         in   words to consume, latched on start
//   i_din            in   FIFO dout, valid whenever i_empty=0
//   i_empty          in   FIFO empty
//   o_rd_en          out  consume i_din this cycle
//   o_busy           out  checker in RUN
//   o_done           out  checker in DONE (level)
//   o_words_read     out  words consumed in the current block
//   o_err_count      out  mismatch count, saturating at 16'hFFFF
//   o_first_err_idx  out  index of first mismatch, 16'hFFFF if none
module fifo_stream_checker
    import fifo_check_pkg::*;
#(
    parameter int          DATA_WIDTH = 16,
    parameter logic [31:0] SEED       = DEF_SEED,
    parameter logic [31:0] POLY       = DEF_POLY,
    parameter logic [7:0]  RATE       = 8'd192
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [15:0]           i_length,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_empty,
    output logic                  o_rd_en,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [15:0]           o_words_read,
    output logic [15:0]           o_err_count,
    output logic [15:0]           o_first_err_idx
);

    state_t      r_state, w_next;
    logic [15:0] r_len, r_words, r_errs, r_first;
    logic [31:0] w_exp;
    logic        w_allow, w_start, w_mismatch;

    assign w_start    = i_start & (r_state == IDLE || r_state == DONE);
    assign w_mismatch = i_din != w_exp[DATA_WIDTH-1:0];
    assign o_rd_en    = (r_state == RUN) & ~i_empty & w_allow & (r_words < r_len);

    lfsr32 #(.POLY(POLY), .INIT(SEED)) u_exp (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_start),
        .i_seed  (SEED),
        .i_step  (o_rd_en),
        .o_state (w_exp)
    );

`ifdef FIFO_STREAM_CHECKER_THROTTLE_EN
    logic [31:0] w_tlfsr;
    logic        w_unused;

    // Free-runs through RUN only; never reloaded, so duty pattern varies per block.
    lfsr32 #(.POLY(POLY), .INIT(32'h1)) u_throttle (
        .clk     (clk),
        .rst     (rst),
        .i_load  (1'b0),
        .i_seed  (32'h0),
        .i_step  (r_state == RUN),
        .o_state (w_tlfsr)
    );

    assign w_allow  = w_tlfsr[7:0] < RATE;
    assign w_unused = ^{w_tlfsr[31:8], w_exp};
`else
    logic w_unused;

    assign w_allow  = 1'b1;
    assign w_unused = ^{RATE, w_exp};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Leave RUN on the consume of the last word so done follows it by one cycle;
    // the words_read==len term covers length=0.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: w_next = i_start ? RUN : r_state;
            RUN:        w_next = (r_words == r_len || (o_rd_en && r_words + 16'd1 == r_len)) ? DONE : RUN;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len   <= 16'h0;
            r_words <= 16'h0;
            r_errs  <= 16'h0;
            r_first <= NO_ERR;
        end else if (w_start) begin
            r_len   <= i_length;
            r_words <= 16'h0;
            r_errs  <= 16'h0;
            r_first <= NO_ERR;
        end else if (o_rd_en) begin
            r_words <= r_words + 16'd1;
            if (w_mismatch && r_errs != 16'hFFFF)
                r_errs <= r_errs + 16'd1;
            if (w_mismatch && r_first == NO_ERR)
                r_first <= r_words;
        end
    end

    assign o_busy          = r_state == RUN;
    assign o_done          = r_state == DONE;
    assign o_words_read    = r_words;
    assign o_err_count     = r_errs;
    assign o_first_err_idx = r_first;

endmodule

// File: tb/tb_fifo_stream_checker.sv
// tb_fifo_stream_checker: randomized self-checking bench for fifo_stream_checker.
// A queue models the FWFT FIFO; expected words, error counts and done timing
// are derived from the block contents and the checker's documented rules.
module tb_fifo_stream_checker;

    localparam logic [31:0] SEED = 32'hACE1_0001;
    localparam logic [31:0] POLY = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic [15:0] i_length = 16'h0;
    logic [15:0] i_din = 16'h0;
    logic        i_empty = 1'b1;
    logic        o_rd_en, o_busy, o_done;
    logic [15:0] o_words_read, o_err_count, o_first_err_idx;

    int n_total = 0;
    int n_bad   = 0;

    fifo_stream_checker #(.DATA_WIDTH(16), .SEED(SEED), .POLY(POLY), .RATE(8'd128)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (i_start),
        .i_length        (i_length),
        .i_din           (i_din),
        .i_empty         (i_empty),
        .o_rd_en         (o_rd_en),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_words_read    (o_words_read),
        .o_err_count     (o_err_count),
        .o_first_err_idx (o_first_err_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] nxt(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? POLY : 32'h0);
    endfunction

    // One block: n words, pe = percent chance a cycle shows empty, bad = index
    // XORed with 1 (-1 none), nrand = extra random corruptions, tog = empty
    // alternates 1/0 every cycle.
    task automatic run_block(input int n, input int pe, input int bad, input int nrand, input bit tog);
        logic [15:0] q[$];
        logic [15:0] ref_w[$];
        logic [31:0] s = SEED;
        int errs = 0, first = 16'hFFFF, cnt = 0, cyc = 0, rds = 0;
        bit run = 1'b1, exp_rd;
        for (int i = 0; i < n; i++) begin
            ref_w.push_back(s[15:0]);
            q.push_back(i == bad ? s[15:0] ^ 16'h1 : s[15:0]);
            s = nxt(s);
        end
        for (int k = 0; k < nrand && n > 0; k++) begin
            int idx = $urandom_range(n - 1);
            q[idx] = q[idx] ^ 16'($urandom_range(1, 16'hFFFF));
        end
        for (int i = 0; i < n; i++)
            if (q[i] != ref_w[i]) begin
                errs++;
                if (first == 16'hFFFF) first = i;
            end
        @(posedge clk); #1;
        i_start = 1'b1;
        i_length = 16'(n);
        @(posedge clk); #1;
        i_start = 1'b0;
        while (run && cyc < 4000) begin
            i_empty = tog ? (cyc % 2 == 0) : (q.size() == 0 || $urandom_range(99) < pe);
            i_din = i_empty ? 16'($urandom) : q[0];
            @(negedge clk);
            exp_rd = !i_empty && cnt < n;
            check("busy", o_busy, 1);
            check("words_read_mid", o_words_read, cnt);
`ifdef FIFO_STREAM_CHECKER_THROTTLE_EN
            check("rd_en_legal", o_rd_en && !exp_rd, 0);
`else
            check("rd_en", o_rd_en, exp_rd);
`endif
            if (o_rd_en) begin
                void'(q.pop_front());
                cnt++;
                rds++;
            end
            if (cnt == n) run = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        i_empty = 1'b1;
        if (run) check("timeout", 1, 0);
        #4;
        check("done", o_done, 1);
        check("busy_end", o_busy, 0);
        check("rd_en_end", o_rd_en, 0);
        check("words_read", o_words_read, n);
        check("err_count", o_err_count, errs);
        check("first_err_idx", o_first_err_idx, first);
        if (tog) check("tog_cycles", cyc, 2 * n);
`ifdef FIFO_STREAM_CHECKER_THROTTLE_EN
        if (n >= 128 && pe == 0) check("duty_40_60", (rds * 100 >= cyc * 40) && (rds * 100 <= cyc * 60), 1);
`else
        if (pe == 0 && !tog) check("zero_bubble", cyc, n == 0 ? 1 : n);
`endif
    endtask

    task automatic reset_mid();
        logic [31:0] s = SEED;
        logic [15:0] q[$];
        int cnt = 0, cyc = 0;
        for (int i = 0; i < 8; i++) begin
            q.push_back(s[15:0]);
            s = nxt(s);
        end
        @(posedge clk); #1;
        i_start = 1'b1;
        i_length = 16'd8;
        @(posedge clk); #1;
        i_start = 1'b0;
        while (cnt < 3 && cyc < 200) begin
            i_empty = 1'b0;
            i_din = q[0];
            @(negedge clk);
            if (o_rd_en) begin
                void'(q.pop_front());
                cnt++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (cnt < 3) check("reset_timeout", 1, 0);
        i_empty = 1'b0;
        i_din = q[0];
        @(negedge clk);
        check("words_pre_rst", o_words_read, 3);
        rst = 1'b0;
        #1;
        check("rst_rd_en", o_rd_en, 0);
        check("rst_words", o_words_read, 0);
        check("rst_done", o_done, 0);
        check("rst_busy", o_busy, 0);
        check("rst_first", o_first_err_idx, 16'hFFFF);
        i_empty = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        #12;
        check("init_rd_en", o_rd_en, 0);
        check("init_busy", o_busy, 0);
        check("init_done", o_done, 0);
        check("init_words", o_words_read, 0);
        check("init_errs", o_err_count, 0);
        check("init_first", o_first_err_idx, 16'hFFFF);
        rst = 1'b1;
        run_block(4, 0, -1, 0, 1'b0);
        run_block(4, 0, 2, 0, 1'b0);
        run_block(8, 0, -1, 0, 1'b1);
        run_block(0, 0, -1, 0, 1'b0);
        reset_mid();
        run_block(5, 0, -1, 0, 1'b0);
        for (int r = 0; r < 20; r++)
            run_block($urandom_range(40), $urandom_range(70), -1, $urandom_range(3), 1'b0);
        run_block(128, 0, -1, 0, 1'b0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
